parallel_serializer: RTL and testbench
======================================

PARALLEL_SERIALIZER -- requirements
Module: parallel_serializer

Interface
REQ-001 Parameter: N, default 32, width of one data word in bits; legal range N >= 1.
REQ-002 Parameter: M, default 2, number of words per parallel frame; legal range M >= 2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 recv_val  input  1  upstream asserts that recv_msg holds a valid frame.
REQ-006 recv_rdy  output  1  block can accept a frame this cycle.
REQ-007 recv_msg  input  M*N  parallel frame; word k occupies bits [k*N+N-1 : k*N].
REQ-008 send_val  output  1  send_msg holds a valid serial word.
REQ-009 send_rdy  input  1  downstream accepts send_msg this cycle.
REQ-010 send_msg  output  N  current serial word.
REQ-011 send_last  output  1  high while the word presented is word M-1 of the frame.

Function
REQ-012 Recv transfer: the recv side completes a transfer in a cycle where recv_val=1 and recv_rdy=1 at the rising edge.
REQ-013 Send transfer: the send side completes a transfer in a cycle where send_val=1 and send_rdy=1 at the rising edge.
REQ-014 The FSM has two states: IDLE and SEND.
REQ-015 In IDLE: recv_rdy=1, send_val=0, send_last=0, send_msg=0.
REQ-016 IDLE -> SEND on a recv transfer: all M words are captured into an internal M x N buffer and word index idx is set to 0.
REQ-017 In SEND: recv_rdy=0, send_val=1, send_msg=buffer[idx], send_last=(idx==M-1).
REQ-018 In SEND, a send transfer with idx<M-1 increments idx and the state remains SEND.
REQ-019 In SEND, a send transfer with idx==M-1 returns the FSM to IDLE and clears idx to 0.
REQ-020 In SEND with send_rdy=0, state, idx and send_msg hold unchanged indefinitely.
REQ-021 Words are emitted in ascending order: word 0 (recv_msg[N-1:0]) first, word M-1 last.
REQ-022 The block has no combinational path from send_rdy to recv_rdy, nor from recv_val to send_val; all outputs are functions of registered state only.
REQ-023 The buffer is written only on a recv transfer; changes on recv_msg at any other time have no effect on send_msg.
REQ-024 idx is a $clog2(M)-bit counter that never exceeds M-1; there is no wrap beyond M-1.
REQ-025 Latency: the first word is valid on send_msg in the cycle after the recv transfer.
REQ-026 Throughput: with send_rdy held at 1, one frame completes every M+1 cycles (M send cycles plus 1 IDLE cycle).
REQ-027 recv_val asserted while in SEND is ignored, and no frame is captured.
REQ-028 send_rdy asserted while in IDLE is ignored.

Reset
REQ-029 A cycle with reset=1 at the rising edge puts the FSM in IDLE, clears idx to 0 and clears the buffer to all zeros.
REQ-030 Reset has priority over any recv or send transfer in the same cycle.
REQ-031 After reset: recv_rdy=1, send_val=0, send_last=0, send_msg=0.
REQ-032 Reset asserted in SEND discards any remaining unsent words, and no partial frame is resumed afterwards.

Verification (N=32, M=2 unless stated)
REQ-033 Basic frame: frame {w1=0xBBBB0002, w0=0xAAAA0001} sent with recv_val=1 and send_rdy held at 1. Required: next cycle send_msg=0xAAAA0001 with send_last=0; following cycle send_msg=0xBBBB0002 with send_last=1; then recv_rdy=1.
REQ-034 Backpressure: send_rdy=0 for 3 cycles after the frame is captured. Required: send_msg stays 0xAAAA0001, send_val stays 1 and recv_rdy stays 0; word 1 appears only after send_rdy=1.
REQ-035 Ignored input: recv_val=1 with a new frame 0x12345678_9ABCDEF0 driven while in SEND. Required: output sequence still 0xAAAA0001 then 0xBBBB0002, and the new frame is not captured.
REQ-036 Reset mid-frame: reset=1 asserted after word 0 is accepted. Required: next cycle send_val=0, send_msg=0, recv_rdy=1; a fresh frame then starts at word 0.
REQ-037 M=4 streaming: 3 back-to-back frames with send_rdy=1, words 0..11 = 0x0..0xB. Required: output sequence 0x0..0xB in order, send_last high on 0x3, 0x7 and 0xB, 15 cycles total.
REQ-038 Random: randomized recv_val and send_rdy over 10k cycles, checked against a FIFO reference model. Required: zero word mismatches and no lost or duplicated words.

Source files
------------

// File: rtl/parallel_serializer.sv
// Parallel-to-serial converter: captures an M-word frame in one handshake and
// emits it one N-bit word at a time over a valid/ready stream, word 0 first.
module parallel_serializer #(
    parameter int N = 32,
    parameter int M = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           recv_val,
    output logic           recv_rdy,
    input  logic [M*N-1:0] recv_msg,
    output logic           send_val,
    input  logic           send_rdy,
    output logic [N-1:0]   send_msg,
    output logic           send_last
);

    localparam int IW = $clog2(M);
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx;
    logic [M-1:0][N-1:0] buffer;
    logic                recv_xfer, send_xfer, at_last;

    assign recv_xfer = recv_val && recv_rdy;
    assign send_xfer = send_val && send_rdy;
    assign at_last   = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (recv_xfer) state_nxt = SEND;
            SEND: if (send_xfer && at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode only registered state, so no handshake input reaches an output combinationally.
    always_comb begin
        recv_rdy  = 1'b0;
        send_val  = 1'b0;
        send_msg  = '0;
        send_last = 1'b0;
        case (state)
            IDLE: recv_rdy = 1'b1;
            SEND: begin
                send_val  = 1'b1;
                send_msg  = buffer[idx];
                send_last = at_last;
            end
            default: recv_rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                idx <= '0;
        else if (recv_xfer)       idx <= '0;
        else if (send_xfer)       idx <= at_last ? '0 : idx + 1'b1;
    end

    // One capture register per word slot of the frame.
    for (genvar k = 0; k < M; k++) begin : g_word
        always_ff @(posedge clk) begin
            if (reset)          buffer[k] <= '0;
            else if (recv_xfer) buffer[k] <= recv_msg[k*N +: N];
        end
    end

endmodule

// File: tb/tb_parallel_serializer.sv
// Self-checking bench: directed frames on an M=2 and an M=4 instance, then
// randomized handshakes on M=2 against a word-queue reference model.
module tb_parallel_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic         recv_val, recv_rdy, send_val, send_rdy, send_last;
    logic [63:0]  recv_msg;
    logic [31:0]  send_msg;
    logic         recv_val4, recv_rdy4, send_val4, send_rdy4, send_last4;
    logic [127:0] recv_msg4;
    logic [31:0]  send_msg4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    parallel_serializer #(.N(32), .M(2)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .send_last(send_last)
    );

    parallel_serializer #(.N(32), .M(4)) dut4 (
        .clk(clk), .reset(reset),
        .recv_val(recv_val4), .recv_rdy(recv_rdy4), .recv_msg(recv_msg4),
        .send_val(send_val4), .send_rdy(send_rdy4), .send_msg(send_msg4),
        .send_last(send_last4)
    );

    task automatic test_reset();
        // recv_val high during reset must not capture
        reset = 1'b1; recv_val = 1'b1; send_rdy = 1'b1; recv_msg = 64'hDEAD_BEEF_0BAD_F00D;
        recv_val4 = 1'b1; send_rdy4 = 1'b1; recv_msg4 = '1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0; recv_val = 1'b0; recv_val4 = 1'b0;
        vectors++;
        if ({recv_rdy, send_val, send_last} !== 3'b100 || send_msg !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_m2 got rdy/val/last=%b msg=%h want 100 msg=0",
                     {recv_rdy, send_val, send_last}, send_msg);
        end
        vectors++;
        if ({recv_rdy4, send_val4, send_last4} !== 3'b100 || send_msg4 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_m4 got rdy/val/last=%b msg=%h want 100 msg=0",
                     {recv_rdy4, send_val4, send_last4}, send_msg4);
        end
    endtask

    task automatic test_basic();
        recv_msg = {32'hBBBB0002, 32'hAAAA0001}; recv_val = 1'b1; send_rdy = 1'b1;
        @(negedge clk);
        recv_val = 1'b0;
        vectors++;
        if (send_val !== 1'b1 || send_msg !== 32'hAAAA0001 || send_last !== 1'b0 || recv_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_w0 got val=%b msg=%h last=%b rdy=%b want 1 aaaa0001 0 0",
                     send_val, send_msg, send_last, recv_rdy);
        end
        @(negedge clk);
        vectors++;
        if (send_val !== 1'b1 || send_msg !== 32'hBBBB0002 || send_last !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_w1 got val=%b msg=%h last=%b want 1 bbbb0002 1",
                     send_val, send_msg, send_last);
        end
        @(negedge clk);
        vectors++;
        if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle got rdy=%b val=%b want 1 0", recv_rdy, send_val);
        end
    endtask

    task automatic test_backpressure();
        recv_msg = {32'hBBBB0002, 32'hAAAA0001}; recv_val = 1'b1; send_rdy = 1'b0;
        @(negedge clk);
        recv_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (send_val !== 1'b1 || send_msg !== 32'hAAAA0001 || recv_rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d got val=%b msg=%h rdy=%b want 1 aaaa0001 0",
                         i, send_val, send_msg, recv_rdy);
            end
            if (i == 3) send_rdy = 1'b1;
            else recv_msg = 64'hFFFF_FFFF_FFFF_FFFF;
            @(negedge clk);
        end
        vectors++;
        if (send_msg !== 32'hBBBB0002 || send_last !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_w1 got msg=%h last=%b want bbbb0002 1", send_msg, send_last);
        end
        @(negedge clk);
        vectors++;
        if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle got rdy=%b val=%b want 1 0", recv_rdy, send_val);
        end
    endtask

    task automatic test_ignored();
        recv_msg = {32'hBBBB0002, 32'hAAAA0001}; recv_val = 1'b1; send_rdy = 1'b1;
        @(negedge clk);
        recv_msg = 64'h12345678_9ABCDEF0;
        vectors++;
        if (send_msg !== 32'hAAAA0001) begin
            miscompares++;
            $display("FAIL ign_w0 got %h want aaaa0001", send_msg);
        end
        @(negedge clk);
        vectors++;
        if (send_msg !== 32'hBBBB0002 || send_last !== 1'b1) begin
            miscompares++;
            $display("FAIL ign_w1 got msg=%h last=%b want bbbb0002 1", send_msg, send_last);
        end
        recv_val = 1'b0;
        @(negedge clk);
        vectors++;
        if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL ign_nocap got val=%b rdy=%b want 0 1", send_val, recv_rdy);
        end
    endtask

    task automatic test_reset_mid();
        recv_msg = {32'hBBBB0002, 32'hAAAA0001}; recv_val = 1'b1; send_rdy = 1'b1;
        @(negedge clk);
        recv_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (send_val !== 1'b0 || send_msg !== 32'h0 || recv_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_clear got val=%b msg=%h rdy=%b want 0 0 1", send_val, send_msg, recv_rdy);
        end
        recv_msg = {32'h0000_0022, 32'h0000_0011}; recv_val = 1'b1;
        @(negedge clk);
        recv_val = 1'b0;
        vectors++;
        if (send_msg !== 32'h11 || send_last !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_w0 got msg=%h last=%b want 00000011 0", send_msg, send_last);
        end
        @(negedge clk);
        vectors++;
        if (send_msg !== 32'h22 || send_last !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_w1 got msg=%h last=%b want 00000022 1", send_msg, send_last);
        end
        @(negedge clk);
    endtask

    task automatic test_stream4();
        for (int k = 0; k < 4; k++) recv_msg4[k*32 +: 32] = 32'(k);
        recv_val4 = 1'b1; send_rdy4 = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            int f, pos;
            @(negedge clk);
            f = (c - 1) / 5;
            pos = (c - 1) % 5;
            vectors++;
            if (pos < 4) begin
                if (send_val4 !== 1'b1 || send_msg4 !== 32'(f*4 + pos) || send_last4 !== (pos == 3)) begin
                    miscompares++;
                    $display("FAIL stream4_c%0d got val=%b msg=%h last=%b want 1 %h %b",
                             c, send_val4, send_msg4, send_last4, f*4 + pos, pos == 3);
                end
            end else if (send_val4 !== 1'b0 || recv_rdy4 !== 1'b1) begin
                miscompares++;
                $display("FAIL stream4_c%0d idle got val=%b rdy=%b want 0 1", c, send_val4, recv_rdy4);
            end
            if (pos == 0) begin
                for (int k = 0; k < 4; k++) recv_msg4[k*32 +: 32] = 32'((f + 1)*4 + k);
                if (f == 2) recv_val4 = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_msg;
        int pops = 0, dut_xfers = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            exp_msg = (q.size() != 0) ? q[0] : 32'h0;
            vectors++;
            if (recv_rdy !== (q.size() == 0) || send_val !== (q.size() != 0) ||
                send_last !== (q.size() == 1) || send_msg !== exp_msg) begin
                miscompares++;
                $display("FAIL rand_c%0d got rdy=%b val=%b last=%b msg=%h want %b %b %b %h",
                         c, recv_rdy, send_val, send_last, send_msg,
                         q.size() == 0, q.size() != 0, q.size() == 1, exp_msg);
            end
            reset    = ($urandom_range(0, 499) == 0);
            recv_val = 1'($urandom_range(0, 1));
            send_rdy = ($urandom_range(0, 3) != 0);
            recv_msg = {$urandom, $urandom};
            if (!reset && send_val && send_rdy) dut_xfers++;
            if (reset) q.delete();
            else if (q.size() == 0) begin
                if (recv_val) begin
                    q.push_back(recv_msg[31:0]);
                    q.push_back(recv_msg[63:32]);
                end
            end else if (send_rdy) begin
                void'(q.pop_front());
                pops++;
            end
        end
        vectors++;
        if (dut_xfers !== pops) begin
            miscompares++;
            $display("FAIL rand_count got %0d send transfers want %0d", dut_xfers, pops);
        end
        reset = 1'b0; recv_val = 1'b0;
    endtask

    initial begin
        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0; recv_msg = '0;
        recv_val4 = 1'b0; send_rdy4 = 1'b0; recv_msg4 = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored();
        test_reset_mid();
        test_stream4();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
